// File: rtl/pixel_pio_receiver.sv
// pixel_pio_receiver: consumes the HPS pixel/status PIO pair. A toggle of the
// status strobe bit marks a new RGB888 pixel. Each pixel is queued in a small
// FIFO and then written into the VGA frame buffer at an auto-incrementing
// address. SOF restarts the address at 0. The block also returns an
// acknowledge toggle, a sticky overflow flag and a frame-done pulse.
module pixel_pio_receiver #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int ADDR_W     = 19,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [31:0]       pixel_data_export,
    input  logic [31:0]       pixel_status_export,
    output logic              fb_wr_en,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [23:0]       fb_wr_data,
    input  logic              fb_wr_ready,
    output logic              pix_ack,
    output logic              overflow,
    output logic              frame_done,
    output logic              busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // Input stage and strobe edge detection
    // ------------------------------------------------------------------
    logic [23:0] d_q;
    logic [2:0]  s_q;
    logic        s_valid_q;   // s_q holds a real sample (not its reset value)
    logic        armed_q;     // prev_tog_q holds a real sample, so edges are trustworthy
    logic        prev_tog_q;
    logic        clr_prev_q;

    // The top PIO bits carry nothing for this block.
    logic unused_bits;
    assign unused_bits = ^{pixel_data_export[31:24], pixel_status_export[31:3]};

    // Register both PIO words and keep the previous strobe/clear levels.
    // Arming waits until prev_tog_q has been loaded from a real sample. A
    // strobe level left high by the HPS across reset is therefore absorbed
    // and does not produce a phantom pixel.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            d_q        <= '0;
            s_q        <= '0;
            s_valid_q  <= 1'b0;
            armed_q    <= 1'b0;
            prev_tog_q <= 1'b0;
            clr_prev_q <= 1'b0;
        end else begin
            d_q        <= pixel_data_export[23:0];
            s_q        <= pixel_status_export[2:0];
            s_valid_q  <= 1'b1;
            armed_q    <= s_valid_q;
            prev_tog_q <= s_q[0];
            clr_prev_q <= s_q[2];
        end
    end

    logic new_pix;
    logic clr_edge;
    assign new_pix  = armed_q & (s_q[0] ^ prev_tog_q);
    assign clr_edge = s_q[2] & ~clr_prev_q;

    // ------------------------------------------------------------------
    // Pixel FIFO: {sof, rgb}
    // ------------------------------------------------------------------
    logic [24:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             drop;
    logic             pop;
    logic [24:0]      head;

    // Fullness uses the pre-pop count. A pop in the same cycle does not make
    // room for a pixel that arrives while the FIFO is full.
    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign push       = new_pix & ~fifo_full;
    assign drop       = new_pix & fifo_full;
    assign head       = mem_q[rd_ptr_q];

    // Storage write port.
    // NOTE: the storage array has no reset; the pointers and count alone decide what is valid.
    always_ff @(posedge clk_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s_q[1], d_q};
        end
    end

    // Next occupancy from simultaneous push/pop.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers and occupancy. The depth is a power of two, so the
    // pointers wrap by plain overflow.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Acknowledge toggle and sticky overflow
    // ------------------------------------------------------------------
    logic pix_ack_q;
    logic overflow_q;

    // Ack flips once per accepted pixel. When a drop and a clear edge happen
    // in the same cycle, the drop wins.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pix_ack_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            pix_ack_q <= pix_ack_q ^ push;
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clr_edge) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame-buffer writer FSM
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [23:0]       data_q, data_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic              frame_done_q, frame_done_d;

    // Next-state and output logic. When a write is accepted, the address
    // counter advances with an explicit wrap at the last pixel of the frame.
    // If another pixel is already queued, it is loaded in the same cycle.
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        wr_en_d      = wr_en_q;
        addr_d       = addr_q;
        data_d       = data_q;
        next_addr_d  = next_addr_q;
        frame_done_d = 1'b0;
        pop          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    data_d  = head[23:0];
                    addr_d  = head[24] ? '0 : next_addr_q;
                    wr_en_d = 1'b1;
                    state_d = ST_WRITE;
                end
            end

            ST_WRITE: begin
                if (fb_wr_ready) begin
                    if (addr_q == LAST_ADDR) begin
                        next_addr_d  = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        next_addr_d = addr_q + ADDR_W'(1);
                    end

                    if (!fifo_empty) begin
                        pop    = 1'b1;
                        data_d = head[23:0];
                        addr_d = head[24] ? '0 : next_addr_d;
                    end else begin
                        wr_en_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                wr_en_d = 1'b0;
            end
        endcase
    end

    // Writer state and registered frame-buffer outputs.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q      <= ST_IDLE;
            wr_en_q      <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            next_addr_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_en_q      <= wr_en_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            next_addr_q  <= next_addr_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign fb_wr_en   = wr_en_q;
    assign fb_addr    = addr_q;
    assign fb_wr_data = data_q;
    assign pix_ack    = pix_ack_q;
    assign overflow   = overflow_q;
    assign frame_done = frame_done_q;
    assign busy       = ~fifo_empty | (state_q == ST_WRITE);

endmodule

// File: doc/pixel_pio_receiver.md
# pixel_pio_receiver

FPGA-side consumer of the HPS pixel PIO pair (`pixel_data_export`, `pixel_status_export`). The HPS writes a 24-bit RGB pixel to the data word, then flips a strobe bit in the status word. This block detects the flip, queues the pixel in a small FIFO, and writes it into the VGA frame buffer at an auto-incrementing address. It also returns an acknowledge toggle and error/frame flags for a future input PIO.

## Interface
- `H_RES`, 640, active pixels per line
- `V_RES`, 480, active lines per frame
- `ADDR_W`, 19, frame-buffer address width; must satisfy 2^ADDR_W ≥ H_RES*V_RES
- `FIFO_DEPTH`, 4, pixel queue entries; power of two, ≥2
- `clk_clk`  in  1  single system clock; all logic on the rising edge
- `reset_reset_n`  in  1  asynchronous, active-low reset
- `pixel_data_export`  in  32  [23:0] RGB888 pixel; [31:24] ignored
- `pixel_status_export`  in  32  [0] strobe toggle; [1] SOF (this pixel goes to address 0); [2] error-clear; [31:3] ignored
- `fb_wr_en`  out  1  frame-buffer write request
- `fb_addr`  out  ADDR_W  write address
- `fb_wr_data`  out  24  RGB888 write data
- `fb_wr_ready`  in  1  frame buffer accepts the write this cycle
- `pix_ack`  out  1  toggles once per pixel accepted into the FIFO
- `overflow`  out  1  sticky: a pixel was dropped because the FIFO was full
- `frame_done`  out  1  one-cycle pulse when the last pixel of a frame is written
- `busy`  out  1  FIFO non-empty or a write is pending

## Operation
- Input stage: both PIO words are registered every cycle (`d_q`, `s_q`). `prev_tog` holds the previous `s_q[0]`.
- Arming: reset clears the `armed` flag. On the first cycle after reset, `prev_tog` loads `s_q[0]` with no edge reported, and `armed` is set. A stale strobe level left by the HPS therefore never produces a phantom pixel.
- New pixel: when `armed` and `s_q[0] != prev_tog`, a new pixel is present. `prev_tog` updates every armed cycle.
- Push on new pixel:
  - If FIFO count < FIFO_DEPTH, push {`s_q[1]`, `d_q[23:0]`} and flip `pix_ack`.
  - Otherwise drop the pixel, set `overflow`, and leave `pix_ack` unchanged.
  - Fullness uses the pre-pop count. A pop in the same cycle does not rescue a push into a full FIFO.
- Error clear: a rising edge of `s_q[2]` clears `overflow`. If a drop happens in the same cycle, set wins.
- Writer FSM:
  - IDLE: if FIFO non-empty, pop the head and load `fb_wr_data`. Load `fb_addr` with 0 if the entry's SOF bit is set, else with `next_addr`. Assert `fb_wr_en` and go to WRITE.
  - WRITE: hold `fb_wr_en`, `fb_addr` and `fb_wr_data` stable until `fb_wr_ready` = 1. On that accepting cycle:
    - set `next_addr` = `fb_addr`+1;
    - if `fb_addr` = H_RES*V_RES−1, set `next_addr` = 0 and pulse `frame_done`;
    - if the FIFO is non-empty, pop and reload in the same cycle and stay in WRITE (back-to-back writes); else drop `fb_wr_en` and go to IDLE.
- Address arithmetic: ADDR_W-bit unsigned with an explicit wrap at H_RES*V_RES−1. No power-of-two wrap is used.
- `busy` = (count ≠ 0) | (state = WRITE).

## Timing
- Reset values: `fb_wr_en`=0, `fb_addr`=0, `fb_wr_data`=0, `pix_ack`=0, `overflow`=0, `frame_done`=0, `busy`=0. Also: `next_addr`=0, FIFO empty, FSM in IDLE, `armed`=0, `prev_tog`=0.
- Latency for a strobe flip visible on the input at edge n:
  - `s_q` captures it at edge n;
  - push and `pix_ack` flip at edge n+1;
  - `fb_wr_en` goes high after edge n+2 if the FIFO was empty and the FSM was in IDLE.
- Throughput: one pixel per cycle while `fb_wr_ready` stays high. The input side accepts one pixel per cycle, because each strobe flip is one pixel.
- `frame_done` is high for exactly the cycle after the accepting edge of the last address.
- Reset asserted mid-write drops `fb_wr_en` immediately (asynchronously). FIFO contents and the partial frame are discarded; the next frame resumes at address 0.

## Test plan
- Reset with status[0]=1 held, then release, then 3 idle cycles → no write, `pix_ack`=0. Then flip status[0] to 0 with data 0x00FF0000 → `pix_ack`=1 at n+1, write {addr 0, 0xFF0000} starting n+2.
- Five pixels with `fb_wr_ready`=1, the second carrying SOF → addresses 0, 0, 1, 2, 3, in order, back-to-back.
- Hold `fb_wr_ready`=0 and flip the strobe 6 times (DEPTH=4) → FIFO takes 4 (3 queued after one loaded into WRITE, then one more), 1 is dropped. `overflow`=1 and `pix_ack` flips 5 times. Release ready → 5 writes, data stable while stalled. Then a status[2] edge → `overflow`=0.
- With H_RES=4, V_RES=2: 9 pixels → addresses 0..7 then 0. `frame_done` pulses once after address 7 is accepted.
- Assert reset while in WRITE with 2 entries queued → `fb_wr_en`=0 immediately. After release, the next pixel writes to address 0.
